// File: rtl/tdm_pkg.sv
// Shared definitions for the two-slot TDM receiver: slot FSM encoding,
// default word width and a sticky-flag update helper.
package tdm_pkg;

    localparam int W_DEF = 8;
    localparam int NSLOT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLOT0 = 2'd1,
        ST_SLOT1 = 2'd2
    } tdm_state_e;

    // Sticky error flag: a clear in the same cycle as a set wins.
    function automatic logic flag_next(input logic cur, input logic set, input logic clr);
        logic nxt;
        if (clr) begin
            nxt = 1'b0;
        end else begin
            nxt = cur | set;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tdm_chan_reg.sv
// Per-channel output holding register: one W-bit word with a valid/ready
// handshake and a sticky overrun flag for words that overwrite unconsumed data.
module tdm_chan_reg
    import tdm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] word,
    input  logic         ready,
    input  logic         err_clr,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overrun
);

    logic accept_s;
    logic lost_s;

    assign accept_s = valid & ready;
    // A word is only lost when the old one is still held and not taken this cycle.
    assign lost_s   = load & valid & ~accept_s;

    // Holding register, valid tracking and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= {W{1'b0}};
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                data  <= word;
                valid <= 1'b1;
            end else if (accept_s) begin
                data  <= data;
                valid <= 1'b0;
            end else begin
                data  <= data;
                valid <= valid;
            end
            overrun <= flag_next(overrun, lost_s, err_clr);
        end
    end

endmodule

// File: rtl/tdm_demux_12.sv
// Receive side of the 2:1 TDM line: after frame_sync, slot 0 then slot 1 each
// deliver W bits MSB first; each recovered word is handed to its own channel register.
module tdm_demux_12
    import tdm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frame_sync,
    input  logic             din,
    output logic [W-1:0]     ch0_data,
    output logic             ch0_valid,
    input  logic             ch0_ready,
    output logic [W-1:0]     ch1_data,
    output logic             ch1_valid,
    input  logic             ch1_ready,
    output logic [NSLOT-1:0] overrun,
    output logic             sync_err,
    input  logic             err_clr
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    tdm_state_e     state_r;
    tdm_state_e     state_nx_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_nx_s;
    logic [W-1:0]   shift_r;
    logic [W-1:0]   shift_nx_s;
    logic [W-1:0]   word_s;
    logic           last_bit_s;
    logic           load0_s;
    logic           load1_s;
    logic           sync_err_set_s;

    assign word_s     = {shift_r[W-2:0], din};
    assign last_bit_s = (cnt_r == CNT_LAST);

    // Slot sequencing, bit counting and frame_sync resynchronisation.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        shift_nx_s     = shift_r;
        load0_s        = 1'b0;
        load1_s        = 1'b0;
        sync_err_set_s = 1'b0;
        if (!en) begin
            // Disabling drops any partial word silently; held words are untouched.
            state_nx_s = ST_IDLE;
            cnt_nx_s   = CNT_ZERO;
            shift_nx_s = {W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_sync) begin
                        state_nx_s = ST_SLOT0;
                        cnt_nx_s   = CNT_ZERO;
                        shift_nx_s = {W{1'b0}};
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_SLOT0: begin
                    if (last_bit_s) begin
                        load0_s    = 1'b1;
                        cnt_nx_s   = CNT_ZERO;
                        shift_nx_s = {W{1'b0}};
                        if (frame_sync) begin
                            state_nx_s     = ST_SLOT0;
                            sync_err_set_s = 1'b1;
                        end else begin
                            state_nx_s = ST_SLOT1;
                        end
                    end else if (frame_sync) begin
                        state_nx_s     = ST_SLOT0;
                        cnt_nx_s       = CNT_ZERO;
                        shift_nx_s     = {W{1'b0}};
                        sync_err_set_s = 1'b1;
                    end else begin
                        shift_nx_s = word_s;
                        cnt_nx_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_SLOT1: begin
                    if (last_bit_s) begin
                        // A sync on the final bit is the next frame starting back-to-back.
                        load1_s    = 1'b1;
                        cnt_nx_s   = CNT_ZERO;
                        shift_nx_s = {W{1'b0}};
                        if (frame_sync) begin
                            state_nx_s = ST_SLOT0;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else if (frame_sync) begin
                        state_nx_s     = ST_SLOT0;
                        cnt_nx_s       = CNT_ZERO;
                        shift_nx_s     = {W{1'b0}};
                        sync_err_set_s = 1'b1;
                    end else begin
                        shift_nx_s = word_s;
                        cnt_nx_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = CNT_ZERO;
                    shift_nx_s = {W{1'b0}};
                end
            endcase
        end
    end

    // FSM state, bit counter, shift register and the sync error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            shift_r  <= {W{1'b0}};
            sync_err <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            cnt_r    <= cnt_nx_s;
            shift_r  <= shift_nx_s;
            sync_err <= flag_next(sync_err, sync_err_set_s, err_clr);
        end
    end

    tdm_chan_reg #(.W(W)) u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .load    (load0_s),
        .word    (word_s),
        .ready   (ch0_ready),
        .err_clr (err_clr),
        .data    (ch0_data),
        .valid   (ch0_valid),
        .overrun (overrun[0])
    );

    tdm_chan_reg #(.W(W)) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .load    (load1_s),
        .word    (word_s),
        .ready   (ch1_ready),
        .err_clr (err_clr),
        .data    (ch1_data),
        .valid   (ch1_valid),
        .overrun (overrun[1])
    );

endmodule

// File: tb/tb_tdm_demux_12.sv
// Bench for tdm_demux_12: a frame-position reference model feeds expected
// per-cycle status and accepted words into queues drained by a negedge monitor.
module tb_tdm_demux_12;

    localparam int W = 8;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic         rst, en, frame_sync, din, ch0_ready, ch1_ready, err_clr;
    logic [W-1:0] ch0_data, ch1_data;
    logic         ch0_valid, ch1_valid, sync_err;
    logic [1:0]   overrun;

    tdm_demux_12 #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .frame_sync (frame_sync),
        .din        (din),
        .ch0_data   (ch0_data),
        .ch0_valid  (ch0_valid),
        .ch0_ready  (ch0_ready),
        .ch1_data   (ch1_data),
        .ch1_valid  (ch1_valid),
        .ch1_ready  (ch1_ready),
        .overrun    (overrun),
        .sync_err   (sync_err),
        .err_clr    (err_clr)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic         v0;
        logic         v1;
        logic [1:0]   ovr;
        logic         serr;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
    } st_t;

    st_t          stq[$];
    logic [W-1:0] exq0[$];
    logic [W-1:0] exq1[$];

    // Reference model: position within the 2W-bit frame, -1 when idle.
    int           m_pos = -1;
    logic         m_fb [0:2*W-1];
    logic         m_v  [0:1];
    logic [W-1:0] m_d  [0:1];
    logic [1:0]   m_ovr;
    logic         m_serr;
    bit           m_known = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic fs, input logic d,
                         input logic r0, input logic r1, input logic ec);
        logic         ld [0:1];
        logic         acc[0:1];
        logic [W-1:0] wd;
        logic [1:0]   ovr_set;
        logic         serr_set;
        int           slot, bitn;
        if (m_known)
            stq.push_back('{m_v[0], m_v[1], m_ovr, m_serr, m_d[0], m_d[1]});
        if (r) begin
            m_pos = -1;
            m_v[0] = 1'b0; m_v[1] = 1'b0;
            m_d[0] = '0;   m_d[1] = '0;
            m_ovr = 2'b00; m_serr = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            acc[0] = m_v[0] & r0;
            acc[1] = m_v[1] & r1;
            if (acc[0]) exq0.push_back(m_d[0]);
            if (acc[1]) exq1.push_back(m_d[1]);
            ld[0] = 1'b0; ld[1] = 1'b0;
            wd = '0; ovr_set = 2'b00; serr_set = 1'b0;
            if (!e) begin
                m_pos = -1;
            end else if (m_pos < 0) begin
                if (fs) m_pos = 0;
            end else begin
                slot = m_pos / W;
                bitn = m_pos % W;
                m_fb[m_pos] = d;
                if (bitn == W - 1) begin
                    ld[slot] = 1'b1;
                    for (int i = 0; i < W; i++) wd[W-1-i] = m_fb[slot*W + i];
                end
                if (fs) begin
                    if (!(slot == 1 && bitn == W - 1)) serr_set = 1'b1;
                    m_pos = 0;
                end else if (m_pos == 2*W - 1) begin
                    m_pos = -1;
                end else begin
                    m_pos++;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (ld[n]) begin
                    if (m_v[n] && !acc[n]) ovr_set[n] = 1'b1;
                    m_v[n] = 1'b1;
                    m_d[n] = wd;
                end else if (acc[n]) begin
                    m_v[n] = 1'b0;
                end
            end
            m_ovr  = ec ? 2'b00 : (m_ovr | ovr_set);
            m_serr = ec ? 1'b0 : (m_serr | serr_set);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic fs, input logic d,
                        input logic r0, input logic r1, input logic ec);
        rst = r; en = e; frame_sync = fs; din = d;
        ch0_ready = r0; ch1_ready = r1; err_clr = ec;
        model(r, e, fs, d, r0, r1, ec);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r0, input logic r1);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom), r0, r1, 1'b0);
    endtask

    task automatic sync(input logic r0, input logic r1);
        step(1'b0, 1'b1, 1'b1, 1'($urandom), r0, r1, 1'b0);
    endtask

    // Sends 2W frame bits MSB first; rd0_mask[i] drives ch0_ready on bit i.
    task automatic xfer(input logic [2*W-1:0] bits, input logic sync_last,
                        input logic [2*W-1:0] rd0_mask, input logic r1);
        for (int i = 0; i < 2*W; i++)
            step(1'b0, 1'b1, sync_last && (i == 2*W - 1), bits[2*W-1-i], rd0_mask[i], r1, 1'b0);
    endtask

    // Monitor: compare each cycle's status and every accepted word.
    always @(negedge clk) begin
        st_t s;
        if (stq.size() != 0) begin
            s = stq.pop_front();
            chk("ch0_valid", 32'(ch0_valid), 32'(s.v0));
            chk("ch1_valid", 32'(ch1_valid), 32'(s.v1));
            chk("ch0_data",  32'(ch0_data),  32'(s.d0));
            chk("ch1_data",  32'(ch1_data),  32'(s.d1));
            chk("overrun",   32'(overrun),   32'(s.ovr));
            chk("sync_err",  32'(sync_err),  32'(s.serr));
        end
        if (!rst && ch0_valid && ch0_ready) begin
            if (exq0.size() == 0) chk("ch0_unexpected_accept", 32'd1, 32'd0);
            else                  chk("ch0_accept_data", 32'(ch0_data), 32'(exq0.pop_front()));
        end
        if (!rst && ch1_valid && ch1_ready) begin
            if (exq1.size() == 0) chk("ch1_unexpected_accept", 32'd1, 32'd0);
            else                  chk("ch1_accept_data", 32'(ch1_data), 32'(exq1.pop_front()));
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_ch0_valid", 32'(ch0_valid), 32'd0);
        chk("rst_ch1_data",  32'(ch1_data),  32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        chk("rst_sync_err",  32'(sync_err),  32'd0);

        // Single frame, consumers always ready.
        idle(2, 1'b1, 1'b1);
        sync(1'b1, 1'b1);
        xfer(16'hA53C, 1'b0, 16'hFFFF, 1'b1);
        idle(3, 1'b1, 1'b1);

        // Two frames with nobody ready: second words overwrite and flag overrun.
        sync(1'b0, 1'b0);
        xfer(16'hA53C, 1'b0, 16'h0000, 1'b0);
        sync(1'b0, 1'b0);
        xfer(16'h1122, 1'b0, 16'h0000, 1'b0);
        idle(1, 1'b0, 1'b0);
        chk("t2_ch0_data", 32'(ch0_data), 32'h11);
        chk("t2_ch1_data", 32'(ch1_data), 32'h22);
        chk("t2_overrun",  32'(overrun),  32'h3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_overrun_clr", 32'(overrun), 32'h0);
        idle(2, 1'b1, 1'b1);

        // Resync three bits into slot 0.
        sync(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom), 1'b1, 1'b1, 1'b0);
        sync(1'b1, 1'b1);
        xfer(16'hC381, 1'b0, 16'hFFFF, 1'b1);
        chk("t3_sync_err", 32'(sync_err), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Back-to-back frames: next sync on the final slot-1 bit.
        sync(1'b1, 1'b1);
        xfer(16'h5AA5, 1'b1, 16'hFFFF, 1'b1);
        xfer(16'h0FF0, 1'b0, 16'hFFFF, 1'b1);
        chk("t4_sync_err", 32'(sync_err), 32'd0);
        idle(2, 1'b1, 1'b1);

        // ch0 accepted in the same cycle a new ch0 word completes.
        sync(1'b0, 1'b1);
        xfer(16'hA53C, 1'b0, 16'h0000, 1'b1);
        sync(1'b0, 1'b1);
        xfer(16'h5A66, 1'b0, 16'h0080, 1'b1);
        chk("t5_overrun0", 32'(overrun[0]), 32'd0);
        chk("t5_ch0_valid", 32'(ch0_valid), 32'd1);
        chk("t5_ch0_data", 32'(ch0_data), 32'h5A);
        idle(2, 1'b1, 1'b1);

        // en drops in slot 1: no ch1 word.
        sync(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(12, 1'b1, 1'b1);
        chk("t6_en_ch1_valid", 32'(ch1_valid), 32'd0);

        // rst in slot 1 with ch0 word still held.
        sync(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_rst_ch0_valid", 32'(ch0_valid), 32'd0);
        chk("t6_rst_ch0_data",  32'(ch0_data),  32'd0);
        chk("t6_rst_overrun",   32'(overrun),   32'd0);
        idle(12, 1'b1, 1'b1);
        chk("t6_rst_ch1_valid", 32'(ch1_valid), 32'd0);

        // Random traffic.
        for (int c = 0; c < 3000; c++)
            step(($urandom_range(399) == 0), ($urandom_range(49) != 0),
                 ($urandom_range(13) == 0), 1'($urandom),
                 ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                 ($urandom_range(59) == 0));

        idle(4, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk("status_queue_drained", 32'(stq.size()), 32'd0);
        chk("ch0_queue_drained", 32'(exq0.size()), 32'd0);
        chk("ch1_queue_drained", 32'(exq1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
